ast_systolic_operand_feeder: RTL and testbench
==============================================

Name: ast_systolic_operand_feeder

Overview:
Per-row operand buffer that sits directly upstream of the systolic array controller's data path. It holds SIZE independent lane FIFOs, one per array row/column edge, filled by the host/DMA side. On each controller `next` pulse it pops one word from every lane enabled by the controller's `memsel` mask. It presents the popped words as a registered, flattened vector, ready for the array's `load_en` cycle. One instance feeds the A edge and one feeds the B edge.

Parameters:
SIZE, 16, number of lanes; equals array dimension and `memsel` width
DATA_W, 8, operand width in bits
DEPTH, 16, words per lane FIFO; power of two, at least 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous flush of all lanes and sticky flags
wr_en  in  1  write strobe
wr_lane  in  $clog2(SIZE)  target lane for the write
wr_data  in  DATA_W  word to write
next  in  1  pop strobe from the controller; one-cycle pulse
memsel  in  SIZE  lane enable mask from the controller; bit i enables lane i
data_out  out  SIZE*DATA_W  popped words; lane i occupies [i*DATA_W +: DATA_W]
out_valid  out  1  one-cycle pulse, asserted the cycle after `next`
empty  out  SIZE  per-lane empty flags
full  out  SIZE  per-lane full flags
overflow  out  1  sticky; a write was dropped
underflow  out  1  sticky; an enabled lane was popped while empty

Behaviour:
- Control priority, highest first: `reset`, `clear`, normal operation. All state updates occur on posedge `clk`.
- Reset values:
  - All read pointers, write pointers and counts are 0.
  - `data_out` = 0, `out_valid` = 0.
  - `empty` = all 1s, `full` = all 0s.
  - `overflow` = 0, `underflow` = 0.
- `clear` produces the same result as reset on all state and outputs. FIFO RAM contents are don't-care.
- Each lane is a circular buffer with read pointer, write pointer and count.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
  - Count is $clog2(DEPTH)+1 bits wide.
- Write:
  - When `wr_en` = 1 and lane `wr_lane` was not full at the start of the cycle, store `wr_data` at the write pointer, advance the pointer, and increment the count.
  - When `wr_en` = 1 and the lane was full, drop the word and set `overflow`. This applies even if the same lane is popped in the same cycle.
- Pop, when `next` = 1, evaluated per lane i:
  - `memsel[i]` = 1 and lane not empty at start of cycle: `data_out` lane i <= head word; advance read pointer; decrement count.
  - `memsel[i]` = 1 and lane empty: `data_out` lane i <= 0; set `underflow`. A write to that lane in the same cycle is stored but not bypassed to the output.
  - `memsel[i]` = 0: `data_out` lane i <= 0; no pointer change.
  - `out_valid` <= 1 in the cycle after `next`, for exactly one cycle.
- When `next` = 0: `data_out` holds its value and `out_valid` <= 0.
- Write and pop on the same lane in the same cycle, lane neither empty nor full: count is unchanged and both pointers advance.
- `empty` and `full` are registered and derived from the post-update count. `empty[i]` = (count == 0); `full[i]` = (count == DEPTH).
- Latency:
  - Write to readable: 1 cycle. A word written in cycle t is poppable by a `next` in cycle t+1.
  - `next` to `data_out`: 1 cycle. Data is valid in the controller's `load_en` cycle.
- Mid-operation `reset` or `clear` discards all buffered data. A `next` coincident with `reset` or `clear` is ignored and `out_valid` stays 0.
- Back-to-back `next` on consecutive cycles is legal, with one pop per cycle per enabled lane.

Test Plan:
- Reset, then write lane 0 with 0x11, 0x22, 0x33; then `next` with `memsel` = 0x0001 three times. Required: `data_out[7:0]` = 0x11, 0x22, 0x33 on successive `out_valid` pulses; other lanes 0; `empty[0]` = 1 at the end.
- Write DEPTH + 1 = 17 words to lane 3. Required: `full[3]` = 1 after the 16th write; 17th word dropped; `overflow` = 1. Then 16 pops return the first 16 words in order.
- Staggered mask: `memsel` sequence 0x0001, 0x0003, 0x0007 with lanes 0..2 preloaded (0xA0.., 0xB0.., 0xC0..). Required: the 3rd pop outputs lane 0 word 3, lane 1 word 2, lane 2 word 1; lanes 3..15 = 0.
- Pop an empty enabled lane 5. Required: lane 5 output = 0, `underflow` = 1; a same-cycle write to lane 5 appears on the following pop.
- Pointer wrap: 40 interleaved write/pop pairs on lane 15. Required: data order preserved, no overflow or underflow, `empty[15]` = 1 at the end.
- Assert `clear`, then `reset`, mid-stream with lanes partially full and `next` asserted in the same cycle. Required: all `empty` = 1, `data_out` = 0, `out_valid` = 0, sticky flags = 0.

Source files
------------

// File: rtl/ast_systolic_operand_feeder_if.sv
// Host/controller-facing bundle of the systolic operand feeder: write port,
// pop control from the array controller, and the popped operand vector with status.
interface ast_systolic_operand_feeder_if #(
    parameter int SIZE   = 16,
    parameter int DATA_W = 8
);
    localparam int LANE_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic                     clear;
    logic                     wr_en;
    logic [LANE_W-1:0]        wr_lane;
    logic [DATA_W-1:0]        wr_data;
    logic                     next;
    logic [SIZE-1:0]          memsel;
    logic [SIZE*DATA_W-1:0]   data_out;
    logic                     out_valid;
    logic [SIZE-1:0]          empty;
    logic [SIZE-1:0]          full;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output clear, wr_en, wr_lane, wr_data, next, memsel,
        input  data_out, out_valid, empty, full, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, wr_lane, wr_data, next, memsel,
        output data_out, out_valid, empty, full, overflow, underflow
    );
endinterface

// File: rtl/ast_systolic_operand_feeder.sv
// SIZE independent lane FIFOs; each controller `next` pops every lane enabled by
// `memsel` into a registered, flattened operand vector for the array load cycle.
module ast_systolic_operand_feeder #(
    parameter int SIZE   = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    ast_systolic_operand_feeder_if.slave  feed_if
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [DATA_W-1:0]      mem_q     [SIZE][DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q  [SIZE];
    logic [PTR_W-1:0]       rd_ptr_d  [SIZE];
    logic [PTR_W-1:0]       wr_ptr_q  [SIZE];
    logic [PTR_W-1:0]       wr_ptr_d  [SIZE];
    logic [CNT_W-1:0]       count_q   [SIZE];
    logic [CNT_W-1:0]       count_d   [SIZE];
    logic [SIZE*DATA_W-1:0] data_out_q, data_out_d;
    logic                   out_valid_q, out_valid_d;
    logic [SIZE-1:0]        empty_q, empty_d;
    logic [SIZE-1:0]        full_q, full_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    logic [SIZE-1:0]        lane_full_s;
    logic [SIZE-1:0]        lane_empty_s;
    logic [SIZE-1:0]        wr_hit_s;
    logic [SIZE-1:0]        pop_s;
    logic                   flush_s;

    assign flush_s = reset | feed_if.clear;

    // Per-lane next-state: fullness/emptiness judged on the count at the start of the cycle.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        empty_d     = empty_q;
        full_d      = full_q;
        lane_full_s  = '0;
        lane_empty_s = '0;
        wr_hit_s     = '0;
        pop_s        = '0;
        for (int i = 0; i < SIZE; i++) begin
            lane_full_s[i]  = (count_q[i] == CNT_W'(DEPTH));
            lane_empty_s[i] = (count_q[i] == CNT_W'(0));
            wr_hit_s[i]     = feed_if.wr_en && (feed_if.wr_lane == LANE_W'(i)) && !lane_full_s[i];
            pop_s[i]        = feed_if.next && feed_if.memsel[i] && !lane_empty_s[i];

            if (wr_hit_s[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i];
            end

            if (pop_s[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end else begin
                rd_ptr_d[i] = rd_ptr_q[i];
            end

            case ({wr_hit_s[i], pop_s[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase

            empty_d[i] = (count_d[i] == CNT_W'(0));
            full_d[i]  = (count_d[i] == CNT_W'(DEPTH));

            // Disabled or starved lanes present zero; a same-cycle write is never bypassed.
            if (feed_if.next) begin
                if (pop_s[i]) begin
                    data_out_d[i*DATA_W +: DATA_W] = mem_q[i][rd_ptr_q[i]];
                end else begin
                    data_out_d[i*DATA_W +: DATA_W] = '0;
                end
            end else begin
                data_out_d[i*DATA_W +: DATA_W] = data_out_q[i*DATA_W +: DATA_W];
            end
        end
        out_valid_d = feed_if.next;
        overflow_d  = overflow_q | (feed_if.wr_en & lane_full_s[feed_if.wr_lane]);
        underflow_d = underflow_q | (feed_if.next & (|(feed_if.memsel & lane_empty_s)));
    end

    // Lane storage; contents are left untouched by reset/clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            if (!flush_s && wr_hit_s[i]) begin
                mem_q[i][wr_ptr_q[i]] <= feed_if.wr_data;
            end
        end
    end

    // Pointer, count, output and sticky-flag registers.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            for (int i = 0; i < SIZE; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            empty_q     <= '1;
            full_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign feed_if.data_out  = data_out_q;
    assign feed_if.out_valid = out_valid_q;
    assign feed_if.empty     = empty_q;
    assign feed_if.full      = full_q;
    assign feed_if.overflow  = overflow_q;
    assign feed_if.underflow = underflow_q;
endmodule

// File: tb/tb_ast_systolic_operand_feeder.sv
// Directed bench for ast_systolic_operand_feeder (SIZE=16, DATA_W=8, DEPTH=16).
module tb_ast_systolic_operand_feeder;
    logic clk;
    logic reset;
    int   n_asserts;
    int   n_fail;

    ast_systolic_operand_feeder_if #(.SIZE(16), .DATA_W(8)) bus_if ();

    ast_systolic_operand_feeder #(.SIZE(16), .DATA_W(8), .DEPTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .feed_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] lane, input logic [7:0] data);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_lane = lane;
        bus_if.wr_data = data;
        tick();
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic do_pop(input logic [15:0] mask);
        bus_if.next   = 1'b1;
        bus_if.memsel = mask;
        tick();
        bus_if.next   = 1'b0;
    endtask

    task automatic check_flushed(input string tag);
        check({tag, "_empty"}, 128'(bus_if.empty), 128'hFFFF);
        check({tag, "_full"}, 128'(bus_if.full), 128'h0);
        check({tag, "_data"}, bus_if.data_out, 128'h0);
        check({tag, "_valid"}, 128'(bus_if.out_valid), 128'h0);
        check({tag, "_ovf"}, 128'(bus_if.overflow), 128'h0);
        check({tag, "_udf"}, 128'(bus_if.underflow), 128'h0);
    endtask

    initial begin
        logic [7:0]   w;
        logic [127:0] exp;
        n_asserts      = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus_if.clear   = 1'b0;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_lane = 4'd0;
        bus_if.wr_data = 8'h00;
        bus_if.next    = 1'b0;
        bus_if.memsel  = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
        check_flushed("reset");

        // Basic in-order pops on lane 0
        do_write(4'd0, 8'h11);
        do_write(4'd0, 8'h22);
        do_write(4'd0, 8'h33);
        check("l0_not_empty", 128'(bus_if.empty[0]), 128'h0);
        do_pop(16'h0001);
        check("l0_pop1", bus_if.data_out, 128'h11);
        check("l0_valid1", 128'(bus_if.out_valid), 128'h1);
        do_pop(16'h0001);
        check("l0_pop2", bus_if.data_out, 128'h22);
        do_pop(16'h0001);
        check("l0_pop3", bus_if.data_out, 128'h33);
        check("l0_empty", 128'(bus_if.empty[0]), 128'h1);
        tick();
        check("valid_drop", 128'(bus_if.out_valid), 128'h0);
        check("data_hold", bus_if.data_out, 128'h33);

        // Fill lane 3 past capacity
        for (int k = 0; k < 16; k++) do_write(4'd3, 8'(8'h40 + k));
        check("l3_full", 128'(bus_if.full[3]), 128'h1);
        check("l3_no_ovf_yet", 128'(bus_if.overflow), 128'h0);
        do_write(4'd3, 8'hEE);
        check("l3_ovf", 128'(bus_if.overflow), 128'h1);
        for (int k = 0; k < 16; k++) begin
            do_pop(16'h0008);
            w   = 8'(8'h40 + k);
            exp = 128'(w) << 24;
            check("l3_pop", bus_if.data_out, exp);
        end
        check("l3_empty", 128'(bus_if.empty[3]), 128'h1);
        check("l3_full_clr", 128'(bus_if.full[3]), 128'h0);
        check("l3_no_udf", 128'(bus_if.underflow), 128'h0);
        bus_if.clear = 1'b1;
        tick();
        bus_if.clear = 1'b0;
        check("clr_ovf", 128'(bus_if.overflow), 128'h0);

        // Staggered mask
        for (int k = 0; k < 3; k++) begin
            do_write(4'd0, 8'(8'hA0 + k));
            do_write(4'd1, 8'(8'hB0 + k));
            do_write(4'd2, 8'(8'hC0 + k));
        end
        do_pop(16'h0001);
        check("stag1", bus_if.data_out, 128'hA0);
        do_pop(16'h0003);
        check("stag2", bus_if.data_out, 128'hB0A1);
        do_pop(16'h0007);
        check("stag3", bus_if.data_out, 128'hC0B1A2);

        // Underflow on lane 5 with a same-cycle write
        bus_if.wr_en   = 1'b1;
        bus_if.wr_lane = 4'd5;
        bus_if.wr_data = 8'h5A;
        do_pop(16'h0020);
        bus_if.wr_en   = 1'b0;
        check("udf_data", bus_if.data_out, 128'h0);
        check("udf_flag", 128'(bus_if.underflow), 128'h1);
        check("udf_valid", 128'(bus_if.out_valid), 128'h1);
        do_pop(16'h0020);
        check("udf_late", bus_if.data_out, 128'h5A << 40);
        check("l5_empty", 128'(bus_if.empty[5]), 128'h1);
        bus_if.clear = 1'b1;
        tick();
        bus_if.clear = 1'b0;
        check_flushed("clr2");

        // Pointer wrap on lane 15 with simultaneous write+pop
        do_write(4'd15, 8'd3);
        for (int k = 1; k < 40; k++) begin
            bus_if.wr_en   = 1'b1;
            bus_if.wr_lane = 4'd15;
            bus_if.wr_data = 8'(k * 7 + 3);
            do_pop(16'h8000);
            bus_if.wr_en   = 1'b0;
            w   = 8'((k - 1) * 7 + 3);
            exp = {w, 120'h0};
            check("wrap_pop", bus_if.data_out, exp);
            check("wrap_not_empty", 128'(bus_if.empty[15]), 128'h0);
        end
        do_pop(16'h8000);
        w   = 8'(39 * 7 + 3);
        exp = {w, 120'h0};
        check("wrap_last", bus_if.data_out, exp);
        check("wrap_empty", 128'(bus_if.empty[15]), 128'h1);
        check("wrap_ovf", 128'(bus_if.overflow), 128'h0);
        check("wrap_udf", 128'(bus_if.underflow), 128'h0);

        // Mid-stream clear with coincident next
        do_write(4'd0, 8'h77);
        do_write(4'd0, 8'h78);
        do_write(4'd7, 8'h99);
        for (int k = 0; k < 17; k++) do_write(4'd4, 8'(k));
        do_pop(16'h0281);
        check("pre_clr_data", bus_if.data_out, (128'h99 << 56) | 128'h77);
        check("pre_clr_flags", {126'h0, bus_if.overflow, bus_if.underflow}, 128'h3);
        bus_if.clear = 1'b1;
        do_pop(16'hFFFF);
        bus_if.clear = 1'b0;
        check_flushed("clr_mid");
        do_pop(16'h0001);
        check("clr_discard", bus_if.data_out, 128'h0);
        check("clr_discard_udf", 128'(bus_if.underflow), 128'h1);

        // Mid-stream reset with coincident next
        do_write(4'd1, 8'h12);
        do_write(4'd1, 8'h13);
        do_pop(16'h0042);
        check("pre_rst_data", bus_if.data_out, 128'h1200);
        reset = 1'b1;
        do_pop(16'hFFFF);
        reset = 1'b0;
        check_flushed("rst_mid");
        do_pop(16'h0002);
        check("rst_discard", bus_if.data_out, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
